// File: rtl/fnn_pkg.sv
// Shared types for the network output stage.
//   state_t : scan controller states (IDLE waits for a capture, SCAN walks the elements).
package fnn_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage : fnn_pkg

// File: rtl/layer_max_finder.sv
// Arg-max over the final fully-connected layer outputs.
// Captures all neuron outputs on i_valid, then compares one element per cycle
// against a running maximum and reports the winning index/value with a
// single-cycle o_data_valid pulse.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_data        : packed neuron outputs, element k at [k*inputWidth +: inputWidth]
//   i_valid       : capture strobe, ignored while busy
//   busy          : high while a scan is in progress (decoded from state)
//   o_index/o_max : last completed result, held until the next scan completes
//   o_data_valid  : one-cycle pulse when o_index/o_max are updated
module layer_max_finder
  import fnn_pkg::*;
#(
  parameter int unsigned numInput   = 10,
  parameter int unsigned inputWidth = 16,
  parameter int unsigned signedCmp  = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [numInput*inputWidth-1:0]       i_data,
  input  logic                                 i_valid,
  output logic                                 busy,
  output logic [$clog2(numInput)-1:0]          o_index,
  output logic [inputWidth-1:0]                o_max,
  output logic                                 o_data_valid
);

  localparam int unsigned DW = numInput * inputWidth;
  localparam int unsigned CW = $clog2(numInput);
  localparam logic [CW-1:0] LAST = CW'(numInput - 1);

  if (numInput < 2) begin : g_param_check
    $error("layer_max_finder: numInput must be >= 2");
  end

  state_t                state_q, state_d;
  logic [DW-1:0]         cap_q, cap_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [inputWidth-1:0] run_max_q, run_max_d;
  logic [CW-1:0]         run_idx_q, run_idx_d;
  logic [CW-1:0]         o_index_d;
  logic [inputWidth-1:0] o_max_d;
  logic                  o_data_valid_d;

  logic [inputWidth-1:0] elem;
  logic                  gt;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cap_q        <= '0;
      cnt_q        <= '0;
      run_max_q    <= '0;
      run_idx_q    <= '0;
      o_index      <= '0;
      o_max        <= '0;
      o_data_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_q        <= cap_d;
      cnt_q        <= cnt_d;
      run_max_q    <= run_max_d;
      run_idx_q    <= run_idx_d;
      o_index      <= o_index_d;
      o_max        <= o_max_d;
      o_data_valid <= o_data_valid_d;
    end
  end

  // Element under test and strict-greater compare; ties keep the lower index.
  always_comb begin
    elem = cap_q[int'(cnt_q)*inputWidth +: inputWidth];
    if (signedCmp != 0) begin
      gt = $signed(elem) > $signed(run_max_q);
    end else begin
      gt = elem > run_max_q;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d        = state_q;
    cap_d          = cap_q;
    cnt_d          = cnt_q;
    run_max_d      = run_max_q;
    run_idx_d      = run_idx_q;
    o_index_d      = o_index;
    o_max_d        = o_max;
    o_data_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          cap_d     = i_data;
          run_max_d = i_data[inputWidth-1:0];
          run_idx_d = '0;
          cnt_d     = CW'(1);
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (gt) begin
          run_max_d = elem;
          run_idx_d = cnt_q;
        end
        if (cnt_q == LAST) begin
          // Final compare folds straight into the published result.
          o_index_d      = gt ? cnt_q : run_idx_q;
          o_max_d        = gt ? elem  : run_max_q;
          o_data_valid_d = 1'b1;
          cnt_d          = '0;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SCAN);

endmodule : layer_max_finder

// File: tb/tb_layer_max_finder.sv
// Self-checking bench for layer_max_finder: one unsigned and one signed
// instance share stimulus; table vectors, corner sequences and random vectors.
module tb_layer_max_finder;

  localparam int unsigned N  = 10;
  localparam int unsigned W  = 16;
  localparam int unsigned DW = N * W;
  localparam int unsigned CW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] i_data;
  logic          i_valid;

  logic          busy_u, dv_u, busy_s, dv_s;
  logic [CW-1:0] idx_u, idx_s;
  logic [W-1:0]  max_u, max_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  layer_max_finder #(.numInput(N), .inputWidth(W), .signedCmp(0)) u_uns (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .busy(busy_u), .o_index(idx_u), .o_max(max_u), .o_data_valid(dv_u)
  );

  layer_max_finder #(.numInput(N), .inputWidth(W), .signedCmp(1)) u_sgn (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .busy(busy_s), .o_index(idx_s), .o_max(max_s), .o_data_valid(dv_s)
  );

  typedef logic [W-1:0] vec_t [N];

  typedef struct {
    vec_t         v;
    int           idx_u;
    logic [W-1:0] max_u;
    int           idx_s;
    logic [W-1:0] max_s;
  } vector_t;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pack(input vec_t v);
    logic [DW-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = v[k];
    return r;
  endfunction

  // Reference arg-max: first occurrence of the largest value.
  function automatic void ref_argmax(input vec_t v, input bit sg, output int idx, output logic [W-1:0] mx);
    idx = 0;
    mx  = v[0];
    for (int k = 1; k < N; k++) begin
      if (sg ? ($signed(v[k]) > $signed(mx)) : (v[k] > mx)) begin
        idx = k;
        mx  = v[k];
      end
    end
  endfunction

  // Launch a scan and wait for its result. Optionally re-pulses i_valid with
  // inj data at scan cycle inj_at. Returns edges from capture to o_data_valid.
  task automatic do_scan(input vec_t v, input int inj_at, input vec_t inj,
                         output int lat, output int busy_cnt);
    i_data  = pack(v);
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (dv_u) begin
        lat = k;
        break;
      end
      if (busy_u) busy_cnt++;
      if (k == inj_at) begin
        i_data  = pack(inj);
        i_valid = 1'b1;
      end
      step();
      i_valid = 1'b0;
    end
  endtask

  task automatic chk_result(input string tag, input int eiu, input logic [W-1:0] emu,
                            input int eis, input logic [W-1:0] ems);
    chk({tag, " idx_u"}, idx_u, eiu);
    chk({tag, " max_u"}, max_u, emu);
    chk({tag, " idx_s"}, idx_s, eis);
    chk({tag, " max_s"}, max_s, ems);
    chk({tag, " dv_s"},  dv_s, 1);
  endtask

  vector_t tbl[5];
  vec_t    zero_v, other_v, rv;
  int      lat, bcnt, dv_seen, eiu, eis;
  logic [W-1:0] emu, ems;

  initial begin
    for (int k = 0; k < N; k++) zero_v[k] = '0;

    tbl[0].v = '{16'd5, 16'd9, 16'd3, 16'd100, 16'd2, 16'd0, 16'd7, 16'd8, 16'd1, 16'd4};
    tbl[0].idx_u = 3; tbl[0].max_u = 16'd100; tbl[0].idx_s = 3; tbl[0].max_s = 16'd100;
    tbl[1].v = '{16'd50, 16'd50, 16'd10, 16'd50, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[1].idx_u = 0; tbl[1].max_u = 16'd50; tbl[1].idx_s = 0; tbl[1].max_s = 16'd50;
    tbl[2].v = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF};
    tbl[2].idx_u = 9; tbl[2].max_u = 16'hFFFF; tbl[2].idx_s = 0; tbl[2].max_s = 16'd0;
    tbl[3].v = '{16'hFFFF, 16'h8000, 16'hFFFE, 16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0,
                 16'hFFF0, 16'hFFF0, 16'hFFF0};
    tbl[3].idx_u = 0; tbl[3].max_u = 16'hFFFF; tbl[3].idx_s = 0; tbl[3].max_s = 16'hFFFF;
    tbl[4].v = '{16'h7FFF, 16'h8000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[4].idx_u = 1; tbl[4].max_u = 16'h8000; tbl[4].idx_s = 0; tbl[4].max_s = 16'h7FFF;

    other_v = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd1000, 16'd6, 16'd7, 16'd8, 16'd9};

    // Reset state
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset busy", busy_u, 0);
    chk("reset dv",   dv_u, 0);
    chk("reset idx",  idx_u, 0);
    chk("reset max",  max_u, 0);
    chk("reset busy_s", busy_s, 0);
    step();

    // Table vectors: latency, busy length, result, single-cycle pulse, hold
    for (int t = 0; t < 5; t++) begin
      do_scan(tbl[t].v, -1, zero_v, lat, bcnt);
      chk($sformatf("vec%0d latency", t), lat, 9);
      chk($sformatf("vec%0d busy cycles", t), bcnt, 9);
      chk_result($sformatf("vec%0d", t), tbl[t].idx_u, tbl[t].max_u, tbl[t].idx_s, tbl[t].max_s);
      step();
      chk($sformatf("vec%0d dv width", t), dv_u, 0);
      chk($sformatf("vec%0d busy after", t), busy_u, 0);
      step();
      chk($sformatf("vec%0d idx hold", t), idx_u, tbl[t].idx_u);
      chk($sformatf("vec%0d max hold", t), max_u, tbl[t].max_u);
    end

    // i_valid re-pulsed 3 cycles into a scan is dropped
    do_scan(tbl[0].v, 3, other_v, lat, bcnt);
    chk("drop latency", lat, 9);
    chk_result("drop", 3, 16'd100, 3, 16'd100);
    dv_seen = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (dv_u || dv_s) dv_seen++;
    end
    chk("drop no second dv", dv_seen, 0);
    chk("drop idx hold", idx_u, 3);

    // Back-to-back: new i_valid in the o_data_valid cycle is accepted
    do_scan(tbl[1].v, -1, zero_v, lat, bcnt);
    chk("b2b first latency", lat, 9);
    do_scan(other_v, -1, zero_v, lat, bcnt);
    chk("b2b second latency", lat, 9);
    chk_result("b2b", 5, 16'd1000, 5, 16'd1000);
    step();

    // Reset asserted at scan cycle 5
    i_data  = pack(tbl[0].v);
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("midrst busy before", busy_u, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst busy", busy_u, 0);
    chk("midrst idx",  idx_u, 0);
    chk("midrst max",  max_u, 0);
    chk("midrst dv",   dv_u, 0);
    dv_seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (dv_u || dv_s) dv_seen++;
    end
    chk("midrst no dv", dv_seen, 0);
    do_scan(tbl[4].v, -1, zero_v, lat, bcnt);
    chk("post-rst latency", lat, 9);
    chk_result("post-rst", 1, 16'h8000, 0, 16'h7FFF);
    step();

    // Random vectors against the reference model
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < N; k++) begin
        if (r % 3 == 0) rv[k] = W'($urandom_range(0, 3));
        else if (r % 3 == 1) rv[k] = W'($urandom_range(16'h7FFE, 16'h8001));
        else rv[k] = W'($urandom);
      end
      ref_argmax(rv, 1'b0, eiu, emu);
      ref_argmax(rv, 1'b1, eis, ems);
      do_scan(rv, -1, zero_v, lat, bcnt);
      chk($sformatf("rnd%0d latency", r), lat, 9);
      chk_result($sformatf("rnd%0d", r), eiu, emu, eis, ems);
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_layer_max_finder
